// File: rtl/skew_feeder.sv
// Diagonal-wavefront read sequencer for a 4x4 operand memory.
// Registers the returned words into a skewed 4-lane stream with a ready/stall handshake.
module skew_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LINES      = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_out_ready,
  output logic [LINES-1:0]              o_read_enable,
  output logic [2*LINES-1:0]            o_read_elem,
  input  logic [LINES*DATA_WIDTH-1:0]   i_mem_data,
  output logic [LINES*DATA_WIDTH-1:0]   o_feed_data,
  output logic [LINES-1:0]              o_feed_valid,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int unsigned STEPS     = LINES + DEPTH - 1;
  localparam logic [2:0]  LAST_STEP = 3'(STEPS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]                    r_state;
  logic [2:0]                    r_step;
  logic [LINES*DATA_WIDTH-1:0]   r_feed_data;
  logic [LINES-1:0]              r_feed_valid;

  logic [LINES-1:0]              w_mask;
  logic [2*LINES-1:0]            w_elem;
  logic [LINES*DATA_WIDTH-1:0]   w_feed_next;
  logic [2:0]                    w_off;

  // Line l is active while 0 <= step-l < DEPTH; the subtraction is only used once step >= l.
  always_comb begin
    w_mask      = '0;
    w_elem      = '0;
    w_feed_next = '0;
    w_off       = '0;
    for (int l = 0; l < int'(LINES); l++) begin
      w_off = r_step - 3'(l);
      if (r_state == ST_RUN && r_step >= 3'(l) && w_off < 3'(DEPTH)) begin
        w_mask[l]                           = 1'b1;
        w_elem[2*l +: 2]                    = w_off[1:0];
        w_feed_next[l*DATA_WIDTH +: DATA_WIDTH] = i_mem_data[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_step       <= '0;
      r_feed_data  <= '0;
      r_feed_valid <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_RUN;
            r_step  <= '0;
          end
        end
        ST_RUN: begin
          if (i_out_ready) begin
            r_feed_data  <= w_feed_next;
            r_feed_valid <= w_mask;
            if (r_step == LAST_STEP) begin
              r_state <= ST_FLUSH;
            end else begin
              r_step <= r_step + 3'd1;
            end
          end
        end
        ST_FLUSH: begin
          if (i_out_ready) begin
            r_feed_data  <= '0;
            r_feed_valid <= '0;
            r_step       <= '0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_step  <= '0;
        end
      endcase
    end
  end

  assign o_read_enable = w_mask;
  assign o_read_elem   = w_elem;
  assign o_feed_data   = r_feed_data;
  assign o_feed_valid  = r_feed_valid;
  assign o_busy        = (r_state != ST_IDLE);
  // The last word is handshaked in FLUSH, so done follows ready there.
  assign o_done        = (r_state == ST_FLUSH) && i_out_ready;

endmodule

// File: tb/tb_skew_feeder.sv
// Scoreboard bench for skew_feeder: a memory model answers reads, expected lane words are
// queued at start and compared at each output handshake.
module tb_skew_feeder;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_out_ready;
  logic [3:0]  o_read_enable;
  logic [7:0]  o_read_elem;
  logic [31:0] i_mem_data;
  logic [31:0] o_feed_data;
  logic [3:0]  o_feed_valid;
  logic        o_busy;
  logic        o_done;

  always #5 i_clk = ~i_clk;

  skew_feeder #(
    .DATA_WIDTH(8),
    .LINES     (4),
    .DEPTH     (4)
  ) u_dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_out_ready  (i_out_ready),
    .o_read_enable(o_read_enable),
    .o_read_elem  (o_read_elem),
    .i_mem_data   (i_mem_data),
    .o_feed_data  (o_feed_data),
    .o_feed_valid (o_feed_valid),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  logic [7:0] mem [4][4];

  always_comb begin
    i_mem_data = '0;
    for (int l = 0; l < 4; l++) begin
      if (o_read_enable[l]) i_mem_data[8*l +: 8] = mem[l][o_read_elem[2*l +: 2]];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_mask(input logic [2:0] t);
    case (t)
      3'd0:    return 4'b0001;
      3'd1:    return 4'b0011;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b1111;
      3'd4:    return 4'b1110;
      3'd5:    return 4'b1100;
      3'd6:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // Entry layout: {done, valid[3:0], data[31:0]}
  logic [36:0] sb_q[$];

  task automatic push_feed();
    logic [3:0]  m;
    logic [31:0] d;
    logic [2:0]  e;
    for (int t = 0; t < 7; t++) begin
      m = exp_mask(3'(t));
      d = '0;
      for (int l = 0; l < 4; l++) begin
        e = 3'(t - l);
        if (m[l]) d[8*l +: 8] = mem[l][e[1:0]];
      end
      sb_q.push_back({(t == 6), m, d});
    end
  endtask

  logic [1:0] m_state;
  logic [2:0] m_step;
  int         m_done_exp = 0;
  int         cyc_cnt    = 0;

  always @(posedge i_clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (i_rst) begin
      m_state <= 2'd0;
      m_step  <= 3'd0;
      sb_q.delete();
    end else begin
      case (m_state)
        2'd0: if (i_start) begin
          m_state <= 2'd1;
          m_step  <= 3'd0;
          push_feed();
        end
        2'd1: if (i_out_ready) begin
          if (m_step == 3'd6) m_state <= 2'd2;
          else m_step <= m_step + 3'd1;
        end
        2'd2: if (i_out_ready) begin
          m_state    <= 2'd0;
          m_done_exp <= m_done_exp + 1;
        end
        default: m_state <= 2'd0;
      endcase
    end
  end

  logic mon_en    = 1'b0;
  logic t6_mode   = 1'b0;
  int   obs_done  = 0;
  int   last_done = -1;

  always @(negedge i_clk) begin
    logic [3:0]  en;
    logic [7:0]  el;
    logic [2:0]  e;
    logic [36:0] ent;
    if (mon_en && !i_rst) begin
      en = '0;
      el = '0;
      if (m_state == 2'd1) begin
        en = exp_mask(m_step);
        for (int l = 0; l < 4; l++) begin
          e = m_step - 3'(l);
          if (en[l]) el[2*l +: 2] = e[1:0];
        end
      end
      check("read_enable", 64'(o_read_enable), 64'(en));
      check("read_elem", 64'(o_read_elem), 64'(el));
      check("busy", 64'(o_busy), 64'(m_state != 2'd0));
      if (o_feed_valid != 4'd0 && i_out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'(1), 64'(0));
        end else begin
          ent = sb_q.pop_front();
          check("feed", 64'({o_done, o_feed_valid, o_feed_data}), 64'(ent));
        end
      end else begin
        check("done_no_handshake", 64'(o_done), 64'(0));
      end
      if (o_done) begin
        obs_done++;
        if (t6_mode && last_done >= 0) check("b2b_period", 64'(cyc_cnt - last_done), 64'(9));
        last_done = cyc_cnt;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
  endtask

  initial begin
    i_rst       = 1'b1;
    i_start     = 1'b0;
    i_out_ready = 1'b1;
    for (int l = 0; l < 4; l++)
      for (int e = 0; e < 4; e++) mem[l][e] = 8'(16 * l + e);
    cyc(3);
    check("rst_feed_data", 64'(o_feed_data), 64'(0));
    check("rst_feed_valid", 64'(o_feed_valid), 64'(0));
    check("rst_read_enable", 64'(o_read_enable), 64'(0));
    check("rst_read_elem", 64'(o_read_elem), 64'(0));
    check("rst_busy_done", 64'({o_busy, o_done}), 64'(0));
    i_rst  = 1'b0;
    mon_en = 1'b1;
    cyc(1);

    // Basic feed with explicit spot checks on cycles 5 and 8.
    pulse_start();
    cyc(4);
    check("t1_c5_valid", 64'(o_feed_valid), 64'(4'hf));
    check("t1_c5_data", 64'(o_feed_data), 64'(32'h3021_1203));
    cyc(3);
    check("t1_c8_valid", 64'(o_feed_valid), 64'(4'b1000));
    check("t1_c8_lane3", 64'(o_feed_data[31:24]), 64'(8'h33));
    check("t1_c8_done", 64'(o_done), 64'(1));
    cyc(1);
    check("t1_c9_busy", 64'(o_busy), 64'(0));
    cyc(3);

    // Stall for 3 cycles at step 3.
    pulse_start();
    cyc(3);
    i_out_ready = 1'b0;
    cyc(3);
    check("t2_stall_elem", 64'(o_read_elem), 64'(8'b00_01_10_11));
    i_out_ready = 1'b1;
    cyc(10);

    // Stall in FLUSH.
    pulse_start();
    cyc(7);
    i_out_ready = 1'b0;
    #1;
    check("t3_flush_done_low", 64'(o_done), 64'(0));
    check("t3_flush_valid", 64'(o_feed_valid), 64'(4'b1000));
    cyc(3);
    i_out_ready = 1'b1;
    #1;
    check("t3_flush_done", 64'(o_done), 64'(1));
    cyc(3);

    // start while busy is ignored.
    pulse_start();
    cyc(2);
    pulse_start();
    cyc(4);
    pulse_start();
    cyc(4);

    // Abort with reset at step 4, then a full feed on new contents.
    for (int l = 0; l < 4; l++)
      for (int e = 0; e < 4; e++) mem[l][e] = 8'($urandom);
    pulse_start();
    cyc(4);
    i_rst = 1'b1;
    cyc(1);
    i_rst = 1'b0;
    check("t5_feed_data", 64'(o_feed_data), 64'(0));
    check("t5_feed_valid", 64'(o_feed_valid), 64'(0));
    check("t5_read_enable", 64'(o_read_enable), 64'(0));
    check("t5_busy_done", 64'({o_busy, o_done}), 64'(0));
    pulse_start();
    cyc(10);

    // start held high: back-to-back feeds.
    t6_mode   = 1'b1;
    last_done = -1;
    i_start   = 1'b1;
    cyc(30);
    i_start = 1'b0;
    cyc(12);
    t6_mode = 1'b0;

    check("sb_drained", 64'(sb_q.size()), 64'(0));
    check("done_count", 64'(obs_done), 64'(m_done_exp));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
